// File: rtl/hwpe_mdc_ctrl_fsm_pkg.sv
// Shared types for the MDC HWPE controller: FSM states, counter width
// derivation and the control/flag bundles seen by the register file side.
package hwpe_mdc_ctrl_package;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    COMPUTE,
    DRAIN,
    NEXT,
    DONE
  } state_e;

  // One extra bit so a count equal to CNT_LEN itself is representable.
  function automatic int unsigned calc_cw(input int unsigned cnt_len);
    return $clog2(cnt_len) + 1;
  endfunction

  typedef struct packed {
    logic kernel_start;
    logic engine_clear;
  } ctrl_t;

  typedef struct packed {
    logic done;
    logic err;
  } flags_t;

endpackage

// File: rtl/hwpe_mdc_ctrl_fsm_out_counter.sv
// Per-output saturating element counter. Reports when the count has reached
// its limit and flags any handshake that arrives once it is already there.
module hwpe_mdc_out_counter
  import hwpe_mdc_ctrl_package::*;
#(
  parameter int unsigned CW = calc_cw(1024)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic          hs_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          ovf_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_o <= '0;
    end else if (en_i && hs_i && (cnt_o < limit_i)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

  // A zero limit reads as full straight away.
  assign full_o = (cnt_o == limit_i);
  assign ovf_o  = en_i && hs_i && full_o;

endmodule

// File: rtl/hwpe_mdc_ctrl_fsm.sv
// Control FSM for MDC HWPE engines with N_IN sources and N_OUT sinks.
// Optional watchdog: define HWPE_MDC_CTRL_FSM_WATCHDOG_EN.
module hwpe_mdc_ctrl_fsm
  import hwpe_mdc_ctrl_package::*;
#(
  parameter int unsigned N_IN        = 2,
  parameter int unsigned N_OUT       = 1,
  parameter int unsigned CNT_LEN     = 1024,
  parameter int unsigned ITER_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 65535,
  localparam int unsigned CW         = calc_cw(CNT_LEN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ITER_W-1:0]   nb_iter_i,
  input  logic [N_OUT*CW-1:0] cnt_limit_i,
  input  logic [N_IN-1:0]     src_ready_i,
  output logic [N_IN-1:0]     src_req_o,
  input  logic [N_OUT-1:0]    sink_ready_i,
  output logic [N_OUT-1:0]    sink_req_o,
  input  logic [N_OUT-1:0]    sink_done_i,
  input  logic [N_OUT-1:0]    out_valid_i,
  input  logic [N_OUT-1:0]    out_ready_i,
  output logic                kernel_start_o,
  input  logic                kernel_done_i,
  output logic                engine_clear_o,
  output logic [N_OUT*CW-1:0] cnt_o,
  output logic [ITER_W-1:0]   iter_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned N_CH = N_IN + N_OUT;

  state_e                state_q;
  logic [N_CH-1:0]       pend_q;
  logic [N_OUT*CW-1:0]   limit_q;
  logic [ITER_W-1:0]     nb_iter_q;
  logic [ITER_W-1:0]     iter_q;
  logic                  kdone_q;
  logic [N_OUT-1:0]      sdone_q;
  ctrl_t                 ctrl_q;
  flags_t                flags_q;

  logic [N_CH-1:0]       ch_ready;
  logic [N_CH-1:0]       ch_grant;
  logic [N_CH-1:0]       pend_left;
  logic [N_OUT-1:0]      cnt_full;
  logic [N_OUT-1:0]      cnt_ovf;
  logic                  cnt_clear;
  logic                  cnt_en;
  logic                  last_iter;
  logic                  wd_hit;

  // Sources occupy the low bits of the channel vector, sinks the high bits.
  // Requests are a ready-qualified view of the pending mask so a channel is
  // served in the very cycle its ready is seen.
  assign ch_ready   = {sink_ready_i, src_ready_i};
  assign ch_grant   = (state_q == ISSUE) ? (pend_q & ch_ready) : '0;
  assign pend_left  = pend_q & ~ch_ready;
  assign src_req_o  = ch_grant[N_IN-1:0];
  assign sink_req_o = ch_grant[N_CH-1:N_IN];

  assign last_iter = ((iter_q + 1'b1) == nb_iter_q);
  assign cnt_en    = (state_q == COMPUTE);
  assign cnt_clear = ((state_q == IDLE) && start_i) || ((state_q == NEXT) && !last_iter);

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    hwpe_mdc_out_counter #(
      .CW(CW)
    ) i_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .hs_i    (out_valid_i[k] & out_ready_i[k]),
      .limit_i (limit_q[k*CW +: CW]),
      .cnt_o   (cnt_o[k*CW +: CW]),
      .full_o  (cnt_full[k]),
      .ovf_o   (cnt_ovf[k])
    );
  end

`ifdef HWPE_MDC_CTRL_FSM_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == ISSUE)) begin
      wd_q <= '0;
    end else if (state_q inside {COMPUTE, DRAIN}) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_hit = (state_q inside {COMPUTE, DRAIN}) && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_hit = 1'b0;
  // Without the watchdog the FSM waits indefinitely and TIMEOUT_CYC has no effect.
  if (TIMEOUT_CYC != 0) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      limit_q   <= '0;
      nb_iter_q <= '0;
      iter_q    <= '0;
      kdone_q   <= 1'b0;
      sdone_q   <= '0;
      ctrl_q    <= '0;
      flags_q   <= '0;
    end else begin
      // NOTE: pulses default low here; a later non-blocking assignment in the
      // same pass overrides this, so each pulse lasts exactly one cycle.
      ctrl_q       <= '0;
      flags_q.done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            limit_q             <= cnt_limit_i;
            nb_iter_q           <= (nb_iter_i == '0) ? ITER_W'(1) : nb_iter_i;
            iter_q              <= '0;
            kdone_q             <= 1'b0;
            sdone_q             <= '0;
            flags_q.err         <= 1'b0;
            pend_q              <= '1;
            ctrl_q.engine_clear <= 1'b1;
            state_q             <= ISSUE;
          end
        end
        ISSUE: begin
          pend_q <= pend_left;
          if (pend_left == '0) begin
            ctrl_q.kernel_start <= 1'b1;
            state_q             <= COMPUTE;
          end
        end
        COMPUTE: begin
          kdone_q <= kdone_q | kernel_done_i;
          sdone_q <= sdone_q | sink_done_i;
          if (|cnt_ovf) flags_q.err <= 1'b1;
          if (wd_hit) begin
            flags_q.err  <= 1'b1;
            flags_q.done <= 1'b1;
            state_q      <= DONE;
          end else if ((&cnt_full) && (kdone_q || kernel_done_i)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          sdone_q <= sdone_q | sink_done_i;
          if (wd_hit) begin
            flags_q.err  <= 1'b1;
            flags_q.done <= 1'b1;
            state_q      <= DONE;
          end else if (&(sdone_q | sink_done_i)) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          iter_q <= iter_q + 1'b1;
          if (last_iter) begin
            flags_q.done <= 1'b1;
            state_q      <= DONE;
          end else begin
            kdone_q             <= 1'b0;
            sdone_q             <= '0;
            pend_q              <= '1;
            ctrl_q.engine_clear <= 1'b1;
            state_q             <= ISSUE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kernel_start_o = ctrl_q.kernel_start;
  assign engine_clear_o = ctrl_q.engine_clear;
  assign done_o         = flags_q.done;
  assign err_o          = flags_q.err;
  assign iter_o         = iter_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_hwpe_mdc_ctrl_fsm.sv
// Self-checking bench for hwpe_mdc_ctrl_fsm: directed jobs plus randomized
// ready/handshake timing, checked against a job-level reference model.
module tb_hwpe_mdc_ctrl_fsm;

  localparam int N_IN        = 2;
  localparam int N_OUT       = 1;
  localparam int CNT_LEN     = 1024;
  localparam int ITER_W      = 16;
  localparam int TIMEOUT_CYC = 16;
  localparam int CW          = $clog2(CNT_LEN) + 1;
  localparam int LW          = N_OUT * CW;
`ifdef HWPE_MDC_CTRL_FSM_WATCHDOG_EN
  localparam bit NO_GAPS = 1'b1;
`else
  localparam bit NO_GAPS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ITER_W-1:0] nb_iter;
  logic [LW-1:0]     cnt_limit;
  logic [N_IN-1:0]   src_ready;
  logic [N_IN-1:0]   src_req;
  logic [N_OUT-1:0]  sink_ready;
  logic [N_OUT-1:0]  sink_req;
  logic [N_OUT-1:0]  sink_done;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic              kernel_start;
  logic              kernel_done;
  logic              engine_clear;
  logic [LW-1:0]     cnt;
  logic [ITER_W-1:0] iter;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;
  logic model_err = 1'b0;

  always #5 clk = ~clk;

  hwpe_mdc_ctrl_fsm #(
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .CNT_LEN    (CNT_LEN),
    .ITER_W     (ITER_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .nb_iter_i     (nb_iter),
    .cnt_limit_i   (cnt_limit),
    .src_ready_i   (src_ready),
    .src_req_o     (src_req),
    .sink_ready_i  (sink_ready),
    .sink_req_o    (sink_req),
    .sink_done_i   (sink_done),
    .out_valid_i   (out_valid),
    .out_ready_i   (out_ready),
    .kernel_start_o(kernel_start),
    .kernel_done_i (kernel_done),
    .engine_clear_o(engine_clear),
    .cnt_o         (cnt),
    .iter_o        (iter),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Channel is low before its turn, high on its turn, don't-care afterwards.
  function automatic logic rdy(input int d, input int i);
    if (i < d) return 1'b0;
    if (i == d) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One complete job. d0/d1/d2: ISSUE-cycle index at which src0/src1/sink0
  // become ready (-1 = random). extra_fix: handshakes beyond the limit (-1 = random).
  task automatic run_job(input int limit, input int nb_iter_arg,
                         input int d0, input int d1, input int d2, input int extra_fix);
    int nb_eff;
    int maxd;
    int h_cnt;
    int h_tot;
    int extra;
    int gap;
    int d[3];
    logic [2:0] exp_req;
    nb_eff = (nb_iter_arg == 0) ? 1 : nb_iter_arg;
    check("idle_busy", busy, 0);
    check("idle_err", err, model_err);
    start      = 1'b1;
    nb_iter    = ITER_W'(nb_iter_arg);
    cnt_limit  = LW'(limit);
    src_ready  = '0;
    sink_ready = '0;
    tick();
    start     = rnd_bit();
    model_err = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clr", err, 0);
    for (int it = 0; it < nb_eff; it++) begin
      d[0] = (d0 >= 0) ? d0 : int'($urandom_range(0, 3));
      d[1] = (d1 >= 0) ? d1 : int'($urandom_range(0, 3));
      d[2] = (d2 >= 0) ? d2 : int'($urandom_range(0, 3));
      maxd = d[0];
      for (int ch = 1; ch < 3; ch++) if (d[ch] > maxd) maxd = d[ch];
      check("issue_iter", iter, it);
      check("issue_cnt", cnt, 0);
      for (int i = 0; i <= maxd + 1; i++) begin
        for (int ch = 0; ch < 3; ch++) exp_req[ch] = (d[ch] == i);
        src_ready[0]  = rdy(d[0], i);
        src_ready[1]  = rdy(d[1], i);
        sink_ready[0] = rdy(d[2], i);
        #1;
        check("engine_clear", engine_clear, (i == 0));
        check("req", {sink_req, src_req}, exp_req);
        check("kernel_start", kernel_start, (i == maxd + 1));
        tick();
        start = rnd_bit();
      end
      extra = (extra_fix >= 0) ? extra_fix : (($urandom_range(0, 3) == 0) ? 1 : 0);
      if (extra > 0) model_err = 1'b1;
      h_tot = limit + extra;
      h_cnt = 0;
      for (int c = 0; c < 64 && h_cnt < h_tot; c++) begin
        check("cnt_run", cnt, min2(h_cnt, limit));
        src_ready  = rnd_bit();
        sink_ready = rnd_bit();
        if (NO_GAPS || ($urandom_range(0, 3) != 0)) begin
          out_valid = 1'b1;
          out_ready = 1'b1;
          h_cnt++;
        end else begin
          {out_valid, out_ready} = 2'($urandom_range(0, 2));
        end
        kernel_done = (h_cnt == h_tot);
        #1;
        check("req_outside_issue", {sink_req, src_req}, 0);
        tick();
        start = rnd_bit();
      end
      if (h_tot == 0) begin
        kernel_done = 1'b1;
        tick();
        start = rnd_bit();
      end
      out_valid   = '0;
      out_ready   = '0;
      kernel_done = 1'b0;
      src_ready   = '0;
      sink_ready  = '0;
      repeat (3) begin
        check("cnt_hold", cnt, min2(h_cnt, limit));
        check("no_early_done", done, 0);
        tick();
        start = rnd_bit();
      end
      check("err_run", err, model_err);
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        tick();
        start = rnd_bit();
      end
      sink_done = 1'b1;
      tick();
      start     = rnd_bit();
      sink_done = 1'b0;
      check("next_done", done, 0);
      check("next_busy", busy, 1);
      tick();
      start = rnd_bit();
      if (it == nb_eff - 1) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_iter", iter, nb_eff);
        check("done_cnt", cnt, limit);
        check("done_err", err, model_err);
        tick();
        start = 1'b0;
        check("after_busy", busy, 0);
        check("after_done", done, 0);
      end else begin
        check("mid_done", done, 0);
      end
    end
  endtask

  task automatic reset_mid_job();
    cnt_limit  = LW'(5);
    nb_iter    = ITER_W'(2);
    src_ready  = '1;
    sink_ready = '1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_pre_ks", kernel_start, 1);
    out_valid = '1;
    out_ready = '1;
    tick();
    tick();
    out_valid = '0;
    out_ready = '0;
    check("rst_pre_cnt", cnt, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_pulses", {kernel_start, engine_clear, done}, 0);
    check("rst_reqs", {sink_req, src_req}, 0);
    check("rst_cnt", cnt, 0);
    check("rst_iter", iter, 0);
    check("rst_err", err, 0);
    src_ready  = '0;
    sink_ready = '0;
    model_err  = 1'b0;
  endtask

`ifdef HWPE_MDC_CTRL_FSM_WATCHDOG_EN
  task automatic watchdog_job();
    cnt_limit  = LW'(3);
    nb_iter    = ITER_W'(1);
    src_ready  = '1;
    sink_ready = '1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("wd_ks", kernel_start, 1);
    src_ready  = '0;
    sink_ready = '0;
    repeat (TIMEOUT_CYC) begin
      check("wd_wait", done, 0);
      tick();
    end
    check("wd_done", done, 1);
    check("wd_err", err, 1);
    tick();
    check("wd_idle", busy, 0);
    model_err = 1'b1;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    nb_iter     = '0;
    cnt_limit   = '0;
    src_ready   = '0;
    sink_ready  = '0;
    sink_done   = '0;
    out_valid   = '0;
    out_ready   = '0;
    kernel_done = 1'b0;
    repeat (3) tick();
    check("reset_outs", {busy, kernel_start, engine_clear, done, err, src_req, sink_req}, 0);
    check("reset_cnt_iter", {cnt, iter}, 0);
    rst = 1'b0;
    tick();
    check("reset_idle", busy, 0);

    run_job(4, 1, 0, 0, 0, 0);     // all ready, one iteration
    run_job(4, 1, 0, 3, 0, 0);     // src1 ready three cycles late
    run_job(2, 3, 0, 0, 0, 0);     // three iterations
    run_job(2, 1, 0, 0, 0, 1);     // one handshake too many
    run_job(3, 1, -1, -1, -1, 0);  // error cleared by this start
    run_job(0, 0, -1, -1, -1, 0);  // zero limit, zero iterations
    reset_mid_job();
    run_job(3, 2, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), -1, -1, -1, -1);
    end
`ifdef HWPE_MDC_CTRL_FSM_WATCHDOG_EN
    watchdog_job();
    run_job(2, 1, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
